// File: rtl/contador_comparador_n.sv
// ---------------------------------------------------------------------------
// contador_comparador_n
//
// Purpose:
//   N-bit loadable up/down modulo counter with unsigned magnitude comparison
//   against an external operand, plus a search FSM. The FSM advances the
//   counter until it equals the operand. If no match is found within MODULO
//   advances, it raises a one-cycle error pulse.
//
// Parameters:
//   N       counter/operand width in bits (2..16)
//   MODULO  count modulus; the count runs over 0..MODULO-1 (2 <= MODULO <= 2**N)
//
// Configuration macro:
//   CONTADOR_SATURA_EN  when defined, the counter saturates at its terminal
//                       value instead of wrapping. An unmatched search then
//                       sits at the terminal value until the timeout fires.
//
// Ports:
//   clock        in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high; clears all state
//   zera         in   1  synchronous clear (Q<=0, FSM->OCIOSO)
//   carrega      in   1  synchronous load (Q<=D, clamped to MODULO-1)
//   conta        in   1  manual count enable (OCIOSO/ENCONTRADO)
//   descendente  in   1  0 = count up, 1 = count down
//   iniciar      in   1  start search (level sampled each edge)
//   D            in   N  load value
//   B            in   N  compare operand
//   Q            out  N  counter value
//   menor        out  1  Q <  B
//   maior        out  1  Q >  B
//   igual        out  1  Q == B
//   fim          out  1  Q at terminal (MODULO-1 up, 0 down)
//   pronto       out  1  high while FSM is in ENCONTRADO
//   erro         out  1  one-cycle pulse on search timeout
//   db_estado    out  2  FSM state: 00 OCIOSO, 01 BUSCA, 10 ENCONTRADO
// ---------------------------------------------------------------------------
module contador_comparador_n #(
    parameter int N      = 4,
    parameter int MODULO = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         carrega,
    input  logic         conta,
    input  logic         descendente,
    input  logic         iniciar,
    input  logic [N-1:0] D,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic         menor,
    output logic         maior,
    output logic         igual,
    output logic         fim,
    output logic         pronto,
    output logic         erro,
    output logic [1:0]   db_estado
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        BUSCA      = 2'b01,
        ENCONTRADO = 2'b10
    } estado_t;

    // The timeout counter must be able to represent MODULO itself.
    localparam int           TW       = $clog2(MODULO + 1);
    localparam logic [N-1:0] TERMINAL = N'(MODULO - 1);

`ifdef CONTADOR_SATURA_EN
    localparam bit SATURA = 1'b1;
`else
    localparam bit SATURA = 1'b0;
`endif

    logic [N-1:0]  r_q;
    estado_t       r_estado;
    logic [TW-1:0] r_timeout;
    logic          r_erro;

    logic [N-1:0]  w_carga;
    logic [N-1:0]  w_prox;

    // Loads above the count range are clamped to the top of the range.
    assign w_carga = (D > TERMINAL) ? TERMINAL : D;

    // Next value when the counter advances (wrap or saturate at terminal).
    always_comb begin
        // NOTE: default assignment first, so no path leaves w_prox unassigned (no latch).
        w_prox = r_q;
        if (descendente) begin
            if (r_q == '0)
                w_prox = SATURA ? r_q : TERMINAL;
            else
                w_prox = r_q - N'(1);
        end else begin
            if (r_q == TERMINAL)
                w_prox = SATURA ? r_q : '0;
            else
                w_prox = r_q + N'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    //       sits in the sensitivity list so it acts without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q       <= '0;
            r_estado  <= OCIOSO;
            r_timeout <= '0;
            r_erro    <= 1'b0;
        end else begin
            r_erro <= 1'b0;
            if (zera) begin
                r_q       <= '0;
                r_estado  <= OCIOSO;
                r_timeout <= '0;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        // The edge that starts a search never advances Q.
                        if (carrega)
                            r_q <= w_carga;
                        else if (conta && !iniciar)
                            r_q <= w_prox;
                        if (iniciar) begin
                            r_estado  <= BUSCA;
                            r_timeout <= '0;
                        end
                    end
                    BUSCA: begin
                        if (carrega) begin
                            r_q       <= w_carga;
                            r_timeout <= '0;
                        end else if (igual) begin
                            r_estado <= ENCONTRADO;
                        end else begin
                            r_q <= w_prox;
                            // This advance is the MODULO-th without a match.
                            if (r_timeout == TW'(MODULO - 1)) begin
                                r_estado  <= OCIOSO;
                                r_erro    <= 1'b1;
                                r_timeout <= '0;
                            end else begin
                                r_timeout <= r_timeout + TW'(1);
                            end
                        end
                    end
                    ENCONTRADO: begin
                        if (carrega)
                            r_q <= w_carga;
                        else if (conta)
                            r_q <= w_prox;
                        if (iniciar) begin
                            r_estado  <= BUSCA;
                            r_timeout <= '0;
                        end
                    end
                    default: r_estado <= OCIOSO;
                endcase
            end
        end
    end

    assign Q         = r_q;
    assign menor     = (r_q <  B);
    assign maior     = (r_q >  B);
    assign igual     = (r_q == B);
    assign fim       = descendente ? (r_q == '0) : (r_q == TERMINAL);
    assign pronto    = (r_estado == ENCONTRADO);
    assign erro      = r_erro;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_contador_comparador_n.sv
module tb_contador_comparador_n;

`ifdef CONTADOR_SATURA_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, zera, carrega, conta, descendente, iniciar;
    logic [3:0] D, B, Q;
    logic       menor, maior, igual, fim, pronto, erro;
    logic [1:0] db_estado;

    int n_vec = 0;
    int n_err = 0;

    contador_comparador_n #(.N(4), .MODULO(10)) dut (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega),
        .conta(conta), .descendente(descendente), .iniciar(iniciar),
        .D(D), .B(B), .Q(Q), .menor(menor), .maior(maior), .igual(igual),
        .fim(fim), .pronto(pronto), .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Advance one rising edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        carrega = 1'b1; D = 4'd3; B = 4'd8;
        tick();
        carrega = 1'b0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        n_vec++; if (Q !== 4'd4 || db_estado !== 2'b01) begin n_err++; $display("FAIL pre_reset got Q=%0d st=%b want Q=4 st=01", Q, db_estado); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (Q !== 4'd0) begin n_err++; $display("FAIL reset_q got=%0d want=0", Q); end
        n_vec++; if (db_estado !== 2'b00) begin n_err++; $display("FAIL reset_state got=%b want=00", db_estado); end
        n_vec++; if (pronto !== 1'b0 || erro !== 1'b0 || fim !== 1'b0) begin n_err++; $display("FAIL reset_flags got pronto=%b erro=%b fim=%b want 0 0 0", pronto, erro, fim); end
        #1 reset = 1'b0;
        tick();
        n_vec++; if (Q !== 4'd0 || db_estado !== 2'b00) begin n_err++; $display("FAIL post_reset got Q=%0d st=%b want Q=0 st=00", Q, db_estado); end
    endtask

    task automatic test_count_up();
        int exp_q   [4];
        bit exp_fim [4];
        exp_q   = '{8, 9, SAT ? 9 : 0, SAT ? 9 : 1};
        exp_fim = '{0, 1, SAT, SAT};
        descendente = 1'b0; carrega = 1'b1; D = 4'd7;
        tick();
        carrega = 1'b0;
        n_vec++; if (Q !== 4'd7 || fim !== 1'b0) begin n_err++; $display("FAIL load7 got Q=%0d fim=%b want Q=7 fim=0", Q, fim); end
        conta = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (Q !== 4'(exp_q[i]) || fim !== exp_fim[i]) begin n_err++; $display("FAIL up_%0d got Q=%0d fim=%b want Q=%0d fim=%b", i, Q, fim, exp_q[i], exp_fim[i]); end
        end
        conta = 1'b0; carrega = 1'b1; D = 4'd13;
        tick();
        n_vec++; if (Q !== 4'd9 || fim !== 1'b1) begin n_err++; $display("FAIL clamp13 got Q=%0d fim=%b want Q=9 fim=1", Q, fim); end
        D = 4'd10;
        tick();
        carrega = 1'b0;
        n_vec++; if (Q !== 4'd9) begin n_err++; $display("FAIL clamp10 got=%0d want=9", Q); end
    endtask

    task automatic test_count_down();
        int exp_q   [3];
        bit exp_fim [3];
        exp_q   = '{0, SAT ? 0 : 9, SAT ? 0 : 8};
        exp_fim = '{1, SAT, SAT};
        carrega = 1'b1; D = 4'd1;
        tick();
        carrega = 1'b0; descendente = 1'b1;
        #1;
        n_vec++; if (Q !== 4'd1 || fim !== 1'b0) begin n_err++; $display("FAIL load1 got Q=%0d fim=%b want Q=1 fim=0", Q, fim); end
        conta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (Q !== 4'(exp_q[i]) || fim !== exp_fim[i]) begin n_err++; $display("FAIL down_%0d got Q=%0d fim=%b want Q=%0d fim=%b", i, Q, fim, exp_q[i], exp_fim[i]); end
        end
        conta = 1'b0; descendente = 1'b0;
    endtask

    task automatic test_search();
        carrega = 1'b1; D = 4'd2; B = 4'd6;
        tick();
        carrega = 1'b0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_vec++; if (db_estado !== 2'b01 || Q !== 4'd2) begin n_err++; $display("FAIL search_start got st=%b Q=%0d want st=01 Q=2", db_estado, Q); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (Q !== 4'(3 + i) || db_estado !== 2'b01) begin n_err++; $display("FAIL search_adv_%0d got Q=%0d st=%b want Q=%0d st=01", i, Q, db_estado, 3 + i); end
            n_vec++; if ({menor, igual, maior} !== ((i == 3) ? 3'b010 : 3'b100)) begin n_err++; $display("FAIL search_cmp_%0d got lt/eq/gt=%b%b%b want %b", i, menor, igual, maior, (i == 3) ? 3'b010 : 3'b100); end
        end
        tick();
        n_vec++; if (db_estado !== 2'b10 || pronto !== 1'b1 || Q !== 4'd6 || igual !== 1'b1) begin n_err++; $display("FAIL found got st=%b pronto=%b Q=%0d igual=%b want 10 1 6 1", db_estado, pronto, Q, igual); end
        tick();
        n_vec++; if (Q !== 4'd6 || pronto !== 1'b1) begin n_err++; $display("FAIL found_hold got Q=%0d pronto=%b want Q=6 pronto=1", Q, pronto); end
    endtask

    task automatic test_back_to_back();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_vec++; if (db_estado !== 2'b01 || pronto !== 1'b0 || Q !== 4'd6) begin n_err++; $display("FAIL restart got st=%b pronto=%b Q=%0d want 01 0 6", db_estado, pronto, Q); end
        tick();
        n_vec++; if (db_estado !== 2'b10 || Q !== 4'd6) begin n_err++; $display("FAIL refound got st=%b Q=%0d want 10 6", db_estado, Q); end
        conta = 1'b1;
        tick();
        conta = 1'b0;
        n_vec++; if (Q !== 4'd7 || pronto !== 1'b1 || maior !== 1'b1 || igual !== 1'b0) begin n_err++; $display("FAIL found_conta got Q=%0d pronto=%b gt=%b eq=%b want 7 1 1 0", Q, pronto, maior, igual); end
    endtask

    // Drives ten unmatched advances from a BUSCA state whose Q is 0 and B=12.
    task automatic run_timeout(input string tag);
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_vec++; if (Q !== 4'(i) || db_estado !== 2'b01 || erro !== 1'b0 || menor !== 1'b1) begin n_err++; $display("FAIL %s_%0d got Q=%0d st=%b erro=%b lt=%b want Q=%0d st=01 erro=0 lt=1", tag, i, Q, db_estado, erro, menor, i); end
        end
        tick();
        n_vec++; if (Q !== (SAT ? 4'd9 : 4'd0) || db_estado !== 2'b00 || erro !== 1'b1 || menor !== 1'b1) begin n_err++; $display("FAIL %s_end got Q=%0d st=%b erro=%b lt=%b want Q=%0d st=00 erro=1 lt=1", tag, Q, db_estado, erro, menor, SAT ? 9 : 0); end
        tick();
        n_vec++; if (erro !== 1'b0 || db_estado !== 2'b00) begin n_err++; $display("FAIL %s_pulse got erro=%b st=%b want 0 00", tag, erro, db_estado); end
    endtask

    task automatic test_timeout();
        zera = 1'b1;
        tick();
        zera = 1'b0; B = 4'd12;
        n_vec++; if (Q !== 4'd0 || db_estado !== 2'b00) begin n_err++; $display("FAIL zera_found got Q=%0d st=%b want 0 00", Q, db_estado); end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        run_timeout("timeout");
    endtask

    task automatic test_carrega_busca();
        zera = 1'b1;
        tick();
        zera = 1'b0; carrega = 1'b1; iniciar = 1'b1; D = 4'd3; B = 4'd12;
        tick();
        carrega = 1'b0; iniciar = 1'b0;
        n_vec++; if (Q !== 4'd3 || db_estado !== 2'b01) begin n_err++; $display("FAIL load_start got Q=%0d st=%b want 3 01", Q, db_estado); end
        repeat (4) tick();
        n_vec++; if (Q !== 4'd7 || db_estado !== 2'b01) begin n_err++; $display("FAIL mid_search got Q=%0d st=%b want 7 01", Q, db_estado); end
        carrega = 1'b1; D = 4'd0;
        tick();
        carrega = 1'b0;
        n_vec++; if (Q !== 4'd0 || db_estado !== 2'b01) begin n_err++; $display("FAIL load_busca got Q=%0d st=%b want 0 01", Q, db_estado); end
        run_timeout("reload");
    endtask

    task automatic test_zera();
        carrega = 1'b1; iniciar = 1'b1; D = 4'd1; B = 4'd8;
        tick();
        carrega = 1'b0; iniciar = 1'b0;
        tick();
        n_vec++; if (Q !== 4'd2 || db_estado !== 2'b01) begin n_err++; $display("FAIL pre_zera got Q=%0d st=%b want 2 01", Q, db_estado); end
        zera = 1'b1; carrega = 1'b1; D = 4'd5;
        tick();
        zera = 1'b0; carrega = 1'b0;
        n_vec++; if (Q !== 4'd0 || db_estado !== 2'b00 || erro !== 1'b0) begin n_err++; $display("FAIL zera_busca got Q=%0d st=%b erro=%b want 0 00 0", Q, db_estado, erro); end
        tick();
        n_vec++; if (Q !== 4'd0 || db_estado !== 2'b00) begin n_err++; $display("FAIL zera_idle got Q=%0d st=%b want 0 00", Q, db_estado); end
    endtask

    initial begin
        reset = 1'b1; zera = 1'b0; carrega = 1'b0; conta = 1'b0;
        descendente = 1'b0; iniciar = 1'b0; D = '0; B = '0;
        #12 reset = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_search();
        test_back_to_back();
        test_timeout();
        test_carrega_busca();
        test_zera();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
